lcd12864_bus_ctrl: RTL



---
 rtl/lcd12864_bus_ctrl.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd12864_bus_ctrl.sv
`timescale 1ns/1ps
// Purpose : shared write-bus controller for a 12864 (ST7920-class) LCD: round-robin
//           arbitration of two {rs, byte} requesters plus E-pulse setup/width/hold/exec timing.
// Latency : accepted write drives lcd_rs/lcd_dat next cycle; E high after T_SETUP cycles.
// Backpressure: reqN_ready only in IDLE (after init); requesters hold valid/data until ready.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   reqN_valid/rs/data, reqN_ready     requester N write channel (N = 0, 1)
//   lcd_rs, lcd_rw, lcd_en, lcd_dat    LCD parallel bus (write-only, lcd_rw tied 0)
//   init_done, busy                    status
// Optional feature macro: LCD12864_INIT_SEQ_EN -- when defined, the block waits T_PWRUP
// cycles after reset and sends 0x30,0x30,0x0C,0x01,0x06 before granting any requester.
module lcd12864_bus_ctrl #(
    parameter int T_SETUP = 4,
    parameter int T_EN    = 25,
    parameter int T_HOLD  = 4,
    parameter int T_EXEC  = 4000,
    parameter int T_CLEAR = 80000,
    parameter int T_PWRUP = 2000000,
    parameter int CNT_W   = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_dat,
    output logic       init_done,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(T_SETUP);
    localparam logic [CNT_W-1:0] C_EN    = CNT_W'(T_EN);
    localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'(T_HOLD);
    localparam logic [CNT_W-1:0] C_EXEC  = CNT_W'(T_EXEC);
    localparam logic [CNT_W-1:0] C_CLEAR = CNT_W'(T_CLEAR);
    localparam logic [CNT_W-1:0] C_PWRUP = CNT_W'(T_PWRUP);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_rs;
    logic [7:0]       r_dat;
    logic             r_en;
    logic             r_last_grant;
    logic             w_last_nxt;
    logic             w_load;
    logic             w_load_rs;
    logic [7:0]       w_load_dat;
    logic             w_cnt_last;
    logic             w_is_clear;
    logic             w_init_done;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_rdy0;
    logic             w_rdy1;

`ifdef LCD12864_INIT_SEQ_EN
    logic       r_init_done;
    logic [2:0] r_idx;
    logic       w_idx_inc;
    logic       w_init_set;

    function automatic logic [7:0] f_init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h30;
            3'd1:    return 8'h30;
            3'd2:    return 8'h0C;
            3'd3:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    assign w_init_done = r_init_done;
`else
    assign w_init_done = 1'b1;
`endif

    // Counter is reloaded to >= 1 on every timed-state entry, so "<= 1" is the last cycle.
    assign w_cnt_last = (r_cnt <= C_ONE);
    // Clear/home commands need the long execution wait.
    assign w_is_clear = !r_rs && ((r_dat == 8'h01) || (r_dat == 8'h02));

    // Tie goes to the side that was not served last.
    assign w_gnt0 = req0_valid && (!req1_valid || r_last_grant);
    assign w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
    assign w_rdy0 = (r_state == S_IDLE) && w_init_done && w_gnt0;
    assign w_rdy1 = (r_state == S_IDLE) && w_init_done && w_gnt1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last_grant;
        w_load      = 1'b0;
        w_load_rs   = r_rs;
        w_load_dat  = r_dat;
`ifdef LCD12864_INIT_SEQ_EN
        w_idx_inc   = 1'b0;
        w_init_set  = 1'b0;
`endif
        case (r_state)
`ifdef LCD12864_INIT_SEQ_EN
            S_PWRUP: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_INIT;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            S_INIT: begin
                w_load      = 1'b1;
                w_load_rs   = 1'b0;
                w_load_dat  = f_init_cmd(r_idx);
                w_idx_inc   = 1'b1;
                w_state_nxt = S_SETUP;
                w_cnt_nxt   = C_SETUP;
            end
`endif
            S_IDLE: begin
                if (w_rdy0) begin
                    w_load      = 1'b1;
                    w_load_rs   = req0_rs;
                    w_load_dat  = req0_data;
                    w_last_nxt  = 1'b0;
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = C_SETUP;
                end else if (w_rdy1) begin
                    w_load      = 1'b1;
                    w_load_rs   = req1_rs;
                    w_load_dat  = req1_data;
                    w_last_nxt  = 1'b1;
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = C_SETUP;
                end
            end
            S_SETUP: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_PULSE;
                    w_cnt_nxt   = C_EN;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            S_PULSE: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = C_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            S_HOLD: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = w_is_clear ? C_CLEAR : C_EXEC;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            S_WAIT: begin
                if (w_cnt_last) begin
`ifdef LCD12864_INIT_SEQ_EN
                    if (!r_init_done && (r_idx != 3'd5)) begin
                        w_state_nxt = S_INIT;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_init_set  = 1'b1;
                    end
`else
                    w_state_nxt = S_IDLE;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef LCD12864_INIT_SEQ_EN
            r_state     <= S_PWRUP;
            r_idx       <= 3'd0;
            r_init_done <= 1'b0;
`else
            r_state     <= S_IDLE;
`endif
            // Counter value is only meaningful in timed states; IDLE ignores it.
            r_cnt        <= C_PWRUP;
            r_rs         <= 1'b0;
            r_dat        <= 8'h00;
            r_en         <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last_grant <= w_last_nxt;
            r_en         <= (w_state_nxt == S_PULSE);
            if (w_load) begin
                r_rs  <= w_load_rs;
                r_dat <= w_load_dat;
            end
`ifdef LCD12864_INIT_SEQ_EN
            if (w_idx_inc) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_init_set) begin
                r_init_done <= 1'b1;
            end
`endif
        end
    end

    assign req0_ready = w_rdy0;
    assign req1_ready = w_rdy1;
    assign lcd_rs     = r_rs;
    assign lcd_rw     = 1'b0;
    assign lcd_en     = r_en;
    assign lcd_dat    = r_dat;
    assign init_done  = w_init_done;
    assign busy       = (r_state != S_IDLE) || !w_init_done;

endmodule
